auv_rom_port_ctrl: RTL

- Shares the bootrom data bridge of the fetch unit between two read-only masters: M0 = load/store unit, M1 = debug port.
- Each master issues 32-bit word reads. The controller splits each read into two 16-bit bridge beats (low half, then high half), reassembles the word and returns it with a single-cycle ack.
- Round-robin arbitration between M0 and M1.
- Every bridge beat steals a fetch cycle, so the controller bounds back-to-back data traffic.

---
 rtl/auv_pkg.sv | 20 ++
 rtl/auv_rr_arb2.sv | 31 +++
 rtl/auv_rom_port_ctrl.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/auv_pkg.sv
// Shared types and constants for the AUV fetch/bootrom path.
package auv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    BEAT_LO,
    BEAT_HI,
    FINISH,
    ERR,
    GAP
  } rom_ctrl_state_e;

  // Fetch unit injects this on a squashed slot.
  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  localparam int unsigned ROM_BEAT_W = 16;
  localparam int unsigned ROM_WORD_W = 32;
  localparam int unsigned GAP_CNT_W  = 4;

endpackage

// File: rtl/auv_rr_arb2.sv
// Two-requester round-robin arbiter; the master not granted last wins a tie.
module auv_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  // High when requester 1 holds the most recent grant.
  logic last_q;

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_q ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else if (advance && (req != 2'b00)) begin
      last_q <= gnt[1];
    end
  end

endmodule

// File: rtl/auv_rom_port_ctrl.sv
// Shares the bootrom bridge between the LSU (M0) and debug port (M1): each 32-bit read
// becomes two 16-bit beats. Optional post-transaction fetch guard: AUV_ROM_FETCH_GUARD_EN.
module auv_rom_port_ctrl
  import auv_pkg::*;
#(
  parameter int unsigned ROM_AW       = 13,
  parameter int unsigned GUARD_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic [ROM_AW-1:0] m0_adr,
  output logic [31:0]       m0_dat,
  output logic              m0_ack,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic [ROM_AW-1:0] m1_adr,
  output logic [31:0]       m1_dat,
  output logic              m1_ack,
  output logic              m1_err,
  output logic [ROM_AW-1:0] rom_adr_o,
  output logic              rom_stb_o,
  output logic              rom_cyc_o,
  input  logic [15:0]       rom_dat_i,
  input  logic              rom_ack_i,
  output logic              busy
);

`ifdef AUV_ROM_FETCH_GUARD_EN
  localparam bit GUARD_EN = 1'b1;
`else
  localparam bit GUARD_EN = 1'b0;
`endif

  localparam logic [GAP_CNT_W-1:0] GAP_LOAD = GAP_CNT_W'(GUARD_CYCLES - 1);

  rom_ctrl_state_e         state_q, state_d;
  logic                    sel_q, sel_d;
  logic [ROM_AW-3:0]       word_q, word_d;
  logic [ROM_BEAT_W-1:0]   lo_q, lo_d;
  logic [GAP_CNT_W-1:0]    gap_cnt_q, gap_cnt_d;
  logic                    rom_stb_q, rom_stb_d;
  logic [ROM_AW-1:0]       rom_adr_q, rom_adr_d;
  logic                    busy_q;

  logic [1:0]              gnt;
  logic                    advance;
  logic [ROM_AW-1:0]       req_adr;
  logic                    done_ack;
  logic                    done_err;
  logic [ROM_WORD_W-1:0]   word_dat;

  auv_rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     ({m1_req, m0_req}),
    .advance (advance),
    .gnt     (gnt)
  );

  // Next-state, beat addressing and word assembly.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    word_d    = word_q;
    lo_d      = lo_q;
    gap_cnt_d = gap_cnt_q;
    rom_stb_d = 1'b0;
    rom_adr_d = rom_adr_q;
    advance   = 1'b0;
    req_adr   = gnt[1] ? m1_adr : m0_adr;

    case (state_q)
      IDLE: begin
        if (gnt != 2'b00) begin
          advance = 1'b1;
          sel_d   = gnt[1];
          word_d  = req_adr[ROM_AW-1:2];
          if (req_adr[1:0] != 2'b00) begin
            state_d = ERR;
          end else begin
            state_d   = BEAT_LO;
            rom_stb_d = 1'b1;
            rom_adr_d = {req_adr[ROM_AW-1:2], 2'b00};
          end
        end
      end
      BEAT_LO: begin
        state_d   = BEAT_HI;
        rom_stb_d = 1'b1;
        rom_adr_d = {word_q, 2'b10};
      end
      BEAT_HI: begin
        if (rom_ack_i) begin
          lo_d    = rom_dat_i;
          state_d = FINISH;
        end else begin
          state_d = ERR;
        end
      end
      FINISH, ERR: begin
        if (GUARD_EN) begin
          state_d   = GAP;
          gap_cnt_d = GAP_LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      GAP: begin
        if (gap_cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sel_q     <= 1'b0;
      word_q    <= '0;
      lo_q      <= '0;
      gap_cnt_q <= '0;
      rom_stb_q <= 1'b0;
      rom_adr_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      word_q    <= word_d;
      lo_q      <= lo_d;
      gap_cnt_q <= gap_cnt_d;
      rom_stb_q <= rom_stb_d;
      rom_adr_q <= rom_adr_d;
      busy_q    <= (state_d != IDLE);
    end
  end

  // Completion depends on the high-half ack arriving in FINISH, so the pulses are decoded
  // from the state register and the bridge ack in the same cycle.
  assign done_ack = (state_q == FINISH) && rom_ack_i;
  assign done_err = ((state_q == FINISH) && !rom_ack_i) || (state_q == ERR);
  assign word_dat = {rom_dat_i, lo_q};

  assign m0_ack = done_ack && !sel_q;
  assign m0_err = done_err && !sel_q;
  assign m0_dat = m0_ack ? word_dat : '0;
  assign m1_ack = done_ack && sel_q;
  assign m1_err = done_err && sel_q;
  assign m1_dat = m1_ack ? word_dat : '0;

  assign rom_stb_o = rom_stb_q;
  assign rom_cyc_o = rom_stb_q;
  assign rom_adr_o = rom_adr_q;
  assign busy      = busy_q;

endmodule
